// File: rtl/alu_xor.sv
// Bitwise XOR unit for the LEGv8 ALU: combinational A^B plus a registered copy with valid/zero/negative flags.
// Optional macro ALU_XOR_PARITY_EN adds a registered even-parity (XOR-reduction) output of result_q.
module alu_xor #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_q,
  output logic                  out_valid,
  output logic                  zero,
  output logic                  negative
`ifdef ALU_XOR_PARITY_EN
  ,
  output logic                  parity
`endif
);

  logic [DATA_WIDTH-1:0] xor_d;

  // The live result feeds the ALU mux directly and stays valid even while in reset.
  assign xor_d  = A ^ B;
  assign result = xor_d;

  // Flags come from the value being captured, so they always match result_q rather than the live operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, so ordering inside this block is irrelevant.
      out_valid <= in_valid;
      if (in_valid) begin
        result_q <= xor_d;
        zero     <= (xor_d == '0);
        negative <= xor_d[DATA_WIDTH-1];
      end
    end
  end

`ifdef ALU_XOR_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (in_valid) begin
      parity <= ^xor_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_xor.sv
// Scoreboard bench for alu_xor: a driver pushes expected registered state per cycle, a monitor pops and compares.
// Also covers walking ones/zeros on the combinational path, async reset mid-stream and ALU_XOR_PARITY_EN.
module tb_alu_xor;
  localparam int W = 64;

  typedef struct {
    logic         v;
    logic [W-1:0] q;
    logic         z;
    logic         n;
    logic         p;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B;
  logic         in_valid;
  logic [W-1:0] result, result_q;
  logic         out_valid, zero, negative;
`ifdef ALU_XOR_PARITY_EN
  logic         parity;
`endif

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];

  // Reference state of the registered outputs, derived from the behavioural rules.
  logic [W-1:0] m_q;
  logic         m_z, m_n, m_p;

  alu_xor #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid),
    .result(result), .result_q(result_q), .out_valid(out_valid),
    .zero(zero), .negative(negative)
`ifdef ALU_XOR_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic ones_parity(input logic [W-1:0] x);
    int cnt = 0;
    for (int i = 0; i < W; i++) if (x[i]) cnt++;
    return logic'(cnt % 2);
  endfunction

  task automatic model_reset();
    m_q = '0; m_z = 1'b0; m_n = 1'b0; m_p = 1'b0;
  endtask

  // Drive one cycle of stimulus at the falling edge and queue what the registers must show after the next rise.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic v);
    exp_t e;
    logic [W-1:0] x;
    @(negedge clk);
    A = a; B = b; in_valid = v;
    x = a ^ b;
    if (v) begin
      m_q = x;
      m_z = (x == 0);
      m_n = (x >= (64'd1 << (W - 1)));
      m_p = ones_parity(x);
    end
    e.v = v; e.q = m_q; e.z = m_z; e.n = m_n; e.p = m_p;
    exp_q.push_back(e);
    #1 check("comb_result", result, x);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_valid", W'(out_valid), W'(e.v));
      check("result_q", result_q, e.q);
      check("zero", W'(zero), W'(e.z));
      check("negative", W'(negative), W'(e.n));
`ifdef ALU_XOR_PARITY_EN
      check("parity", W'(parity), W'(e.p));
`endif
    end
  end

  task automatic drain();
    int budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    check("scoreboard_drained", W'(exp_q.size()), '0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst_n = 1'b0; A = '0; B = '0; in_valid = 1'b0;
    model_reset();
    #1;
    check("rst_result_q", result_q, '0);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_zero", W'(zero), '0);
    check("rst_negative", W'(negative), '0);
`ifdef ALU_XOR_PARITY_EN
    check("rst_parity", W'(parity), '0);
`endif

    // Walking ones, run while reset is held: the combinational path must not care.
    a = '0; b = '0;
    for (int i = 0; i < W; i++) begin
      a[i] = 1'b1;
      for (int j = 0; j < W; j++) begin
        b[j] = 1'b1;
        A = a; B = b;
        #1 check("walk_ones", result, a ^ b);
      end
      b = '0;
    end
    check("rst_still_invalid", W'(out_valid), '0);

    @(negedge clk); rst_n = 1'b1;

    // Walking zeros.
    a = '1; b = '1;
    for (int i = 0; i < W; i++) begin
      a[i] = 1'b0;
      for (int j = 0; j < W; j++) begin
        b[j] = 1'b0;
        A = a; B = b;
        #1 check("walk_zeros", result, a ^ b);
      end
      b = '1;
    end

    // Registered path and boundaries.
    drive(64'hDEAD_BEEF_0000_0000, 64'hDEAD_BEEF_0000_0000, 1'b1);
    drive(64'h8000_0000_0000_0000, 64'h0, 1'b1);
    drive(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    drive(64'h0, 64'h0, 1'b0);
    drive(64'h7, 64'h0, 1'b1);
    drive(64'h3, 64'h0, 1'b1);
    drive(64'h5, 64'h5, 1'b1);
    drive(64'h1, 64'h3, 1'b1);
    drive(64'hAAAA_0000_5555_FFFF, 64'h1, 1'b0);
    drain();

    // Async reset between edges while out_valid is high.
    drive(64'h8000_0000_0000_0007, 64'h0, 1'b1);
    drain();
    check("pre_reset_valid", W'(out_valid), W'(1'b1));
    @(negedge clk); #2;
    A = 64'hCAFE_F00D_0000_1111; B = 64'h0000_FFFF_0000_FFFF;
    rst_n = 1'b0;
    #1;
    check("async_rst_result_q", result_q, '0);
    check("async_rst_valid", W'(out_valid), '0);
    check("async_rst_zero", W'(zero), '0);
    check("async_rst_negative", W'(negative), '0);
`ifdef ALU_XOR_PARITY_EN
    check("async_rst_parity", W'(parity), '0);
`endif
    check("async_rst_comb", result, 64'hCAFE_F00D_0000_1111 ^ 64'h0000_FFFF_0000_FFFF);
    // A capture requested while reset is still held must be discarded.
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_held_discard_q", result_q, '0);
    check("rst_held_discard_valid", W'(out_valid), '0);
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
    model_reset();

    // Hold after reset without capture keeps zero low even though result_q is zero.
    drive(64'h0, 64'h0, 1'b0);

    // Randomized traffic with boundary bias.
    for (int k = 0; k < 300; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: b = a;
        1: begin a = '1; b = '0; end
        2: a = b ^ (64'd1 << $urandom_range(0, W - 1));
        default: ;
      endcase
      drive(a, b, logic'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
